// File: rtl/pc_next_unit.sv
// Program counter and next-PC selection for the single-cycle MIPS core.
// Includes stall/halt control, jr misalignment trap and a saturating retire counter.
module pc_next_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             halt_req,
   input  logic             branch,
   input  logic             branch_not,
   input  logic             jump,
   input  logic             jump_reg,
   input  logic             zero,
   input  logic [15:0]      imm16,
   input  logic [25:0]      target26,
   input  logic [31:0]      rs_data,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic [31:0]      next_pc,
   output logic             halted,
   output logic             misaligned,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic        take_br;
   logic        jr_bad;

   assign pc_plus4  = pc_q + 32'd4;
   assign br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
   assign j_target  = {pc_plus4[31:28], target26, 2'b00};
   assign take_br   = (branch & zero) | (branch_not & ~zero);
   assign jr_bad    = jump_reg & (rs_data[1:0] != 2'b00);

   always_comb begin
      next_pc = pc_plus4;
      if (jump_reg) begin
         next_pc = rs_data;
      end else if (jump) begin
         next_pc = j_target;
      end else if (take_br) begin
         next_pc = br_target;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StRun;
         pc_q        <= RESET_PC;
         instr_count <= '0;
         misaligned  <= 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (jr_bad) begin
                  misaligned <= 1'b1;
                  state_q    <= StHalt;
               end else if (halt_req) begin
                  state_q <= StHalt;
               end else if (!stall) begin
                  pc_q <= next_pc;
                  // Saturate rather than wrap so overflow is observable.
                  if (instr_count != {CNT_W{1'b1}}) begin
                     instr_count <= instr_count + 1'b1;
                  end
               end
            end
            StHalt: begin
            end
            default: state_q <= StHalt;
         endcase
      end
   end

   assign pc     = pc_q;
   assign halted = (state_q == StHalt);

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus randomized run
// against a behavioural model of the PC/counter rules.
module tb_pc_next_unit;

   logic        clk = 1'b0;
   logic        rst_n, stall, halt_req, branch, branch_not, jump, jump_reg, zero;
   logic [15:0] imm16;
   logic [25:0] target26;
   logic [31:0] rs_data;
   logic [31:0] pc, pc_plus4, next_pc;
   logic        halted, misaligned;
   logic [31:0] instr_count;
   logic [31:0] pc4, pc_plus4_4, next_pc4;
   logic        halted4, misaligned4;
   logic [3:0]  instr_count4;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   logic [31:0] m_pc;
   longint      m_cnt;
   int          m_cnt4;
   bit          m_halt, m_mis;

   always #5 clk = ~clk;

   pc_next_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .halt_req(halt_req), .branch(branch),
      .branch_not(branch_not), .jump(jump), .jump_reg(jump_reg), .zero(zero),
      .imm16(imm16), .target26(target26), .rs_data(rs_data), .pc(pc),
      .pc_plus4(pc_plus4), .next_pc(next_pc), .halted(halted),
      .misaligned(misaligned), .instr_count(instr_count)
   );

   pc_next_unit #(.RESET_PC(32'h0), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .halt_req(halt_req), .branch(branch),
      .branch_not(branch_not), .jump(jump), .jump_reg(jump_reg), .zero(zero),
      .imm16(imm16), .target26(target26), .rs_data(rs_data), .pc(pc4),
      .pc_plus4(pc_plus4_4), .next_pc(next_pc4), .halted(halted4),
      .misaligned(misaligned4), .instr_count(instr_count4)
   );

   function automatic logic [31:0] ref_next();
      logic [31:0] link;
      int          off;
      link = m_pc + 32'd4;
      off  = $signed(imm16);
      if (jump_reg) return rs_data;
      if (jump) return {link[31:28], target26, 2'b00};
      if ((branch && zero) || (branch_not && !zero)) return link + 32'(off * 4);
      return link;
   endfunction

   task automatic idle();
      stall = 0; halt_req = 0; branch = 0; branch_not = 0; jump = 0; jump_reg = 0;
      zero = 0; imm16 = '0; target26 = '0; rs_data = '0;
   endtask

   // Advance the model by the rules for one rising edge, then let the DUT take it.
   task automatic tick();
      logic [31:0] nxt;
      nxt = ref_next();
      if (!rst_n) begin
         m_pc = 32'h0; m_cnt = 0; m_cnt4 = 0; m_halt = 0; m_mis = 0;
      end else if (!m_halt) begin
         if (jump_reg && rs_data[1:0] != 2'b00) begin
            m_mis = 1; m_halt = 1;
         end else if (halt_req) begin
            m_halt = 1;
         end else if (!stall) begin
            m_pc = nxt;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   task automatic set_pc(input logic [31:0] a);
      idle();
      jump_reg = 1; rs_data = a;
      tick();
      idle();
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      tick();
      tick();
      n_tests++;
      if (pc !== 32'h0 || instr_count !== 32'd0 || halted !== 1'b0 || misaligned !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: pc=%h cnt=%0d halted=%b mis=%b, want 0/0/0/0",
                  pc, instr_count, halted, misaligned);
      end
      rst_n = 1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_tests++;
         if (pc !== 32'(4 * i)) begin
            n_fail++;
            $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 32'(4 * i));
         end
      end
      n_tests++;
      if (instr_count !== 32'd3) begin
         n_fail++;
         $display("FAIL seq_count: got %0d want 3", instr_count);
      end
      rst_n = 0;
      tick();
      rst_n = 1;
      n_tests++;
      if (pc !== 32'h0 || instr_count !== 32'd0) begin
         n_fail++;
         $display("FAIL midrun_reset: pc=%h cnt=%0d want 0/0", pc, instr_count);
      end
   endtask

   task automatic test_branch();
      set_pc(32'h40);
      branch = 1; zero = 1; imm16 = 16'hFFFE;
      #1;
      n_tests++;
      if (next_pc !== 32'h3C) begin
         n_fail++;
         $display("FAIL beq_next_pc: got %h want 0000003c", next_pc);
      end
      tick();
      n_tests++;
      if (pc !== 32'h3C) begin
         n_fail++;
         $display("FAIL beq_taken: got %h want 0000003c", pc);
      end
      set_pc(32'h40);
      branch = 1; zero = 0; imm16 = 16'hFFFE;
      tick();
      n_tests++;
      if (pc !== 32'h44) begin
         n_fail++;
         $display("FAIL beq_not_taken: got %h want 00000044", pc);
      end
      set_pc(32'h40);
      branch_not = 1; zero = 0; imm16 = 16'h0003;
      tick();
      n_tests++;
      if (pc !== 32'h50) begin
         n_fail++;
         $display("FAIL bne_taken: got %h want 00000050", pc);
      end
      set_pc(32'h40);
      branch = 1; branch_not = 1; zero = 1'($urandom); imm16 = 16'h0004;
      tick();
      n_tests++;
      if (pc !== 32'h54) begin
         n_fail++;
         $display("FAIL both_branch: got %h want 00000054", pc);
      end
   endtask

   task automatic test_jump();
      set_pc(32'h1000_0040);
      jump = 1; target26 = 26'h10;
      #1;
      n_tests++;
      if (pc_plus4 !== 32'h1000_0044) begin
         n_fail++;
         $display("FAIL jal_link: got %h want 10000044", pc_plus4);
      end
      tick();
      n_tests++;
      if (pc !== 32'h1000_0040) begin
         n_fail++;
         $display("FAIL jump_target: got %h want 10000040", pc);
      end
      idle();
      jump_reg = 1; jump = 1; target26 = 26'h3FF_FFFF; rs_data = 32'h200;
      tick();
      n_tests++;
      if (pc !== 32'h200) begin
         n_fail++;
         $display("FAIL jr_priority: got %h want 00000200", pc);
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] cnt_before;
      set_pc(32'h80);
      cnt_before = instr_count;
      jump_reg = 1; rs_data = 32'h1003; halt_req = 1;
      tick();
      n_tests++;
      if (pc !== 32'h80 || misaligned !== 1'b1 || halted !== 1'b1 || instr_count !== cnt_before) begin
         n_fail++;
         $display("FAIL misaligned_jr: pc=%h mis=%b halted=%b cnt=%0d want 80/1/1/%0d",
                  pc, misaligned, halted, instr_count, cnt_before);
      end
      for (int i = 0; i < 6; i++) begin
         stall = 1'($urandom); halt_req = 1'($urandom); branch = 1'($urandom);
         jump = 1'($urandom); jump_reg = 1'($urandom); zero = 1'($urandom);
         imm16 = 16'($urandom); target26 = 26'($urandom); rs_data = $urandom & 32'hFFFF_FFFC;
         tick();
      end
      n_tests++;
      if (pc !== 32'h80 || misaligned !== 1'b1 || halted !== 1'b1 || instr_count !== cnt_before) begin
         n_fail++;
         $display("FAIL halt_holds: pc=%h mis=%b halted=%b cnt=%0d want 80/1/1/%0d",
                  pc, misaligned, halted, instr_count, cnt_before);
      end
      do_reset();
      n_tests++;
      if (pc !== 32'h0 || misaligned !== 1'b0 || halted !== 1'b0 || instr_count !== 32'd0) begin
         n_fail++;
         $display("FAIL halt_reset: pc=%h mis=%b halted=%b cnt=%0d want 0/0/0/0",
                  pc, misaligned, halted, instr_count);
      end
   endtask

   task automatic test_stall_halt();
      logic [31:0] cnt_before;
      set_pc(32'h20);
      cnt_before = instr_count;
      stall = 1; branch = 1; zero = 1; imm16 = 16'h0100;
      for (int i = 0; i < 3; i++) tick();
      n_tests++;
      if (pc !== 32'h20 || instr_count !== cnt_before || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_hold: pc=%h cnt=%0d halted=%b want 20/%0d/0",
                  pc, instr_count, halted, cnt_before);
      end
      halt_req = 1;
      tick();
      n_tests++;
      if (halted !== 1'b1 || pc !== 32'h20 || misaligned !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_over_stall: halted=%b pc=%h mis=%b want 1/20/0",
                  halted, pc, misaligned);
      end
      do_reset();
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) tick();
      n_tests++;
      if (instr_count4 !== 4'hF || pc4 !== 32'h50) begin
         n_fail++;
         $display("FAIL saturation: cnt4=%h pc4=%h want f/00000050", instr_count4, pc4);
      end
      n_tests++;
      if (instr_count !== 32'd20 || pc !== 32'h50) begin
         n_fail++;
         $display("FAIL count20: cnt=%0d pc=%h want 20/00000050", instr_count, pc);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst_n      = ($urandom_range(0, 29) != 0);
         stall      = ($urandom_range(0, 4) == 0);
         halt_req   = ($urandom_range(0, 39) == 0);
         branch     = 1'($urandom);
         branch_not = ($urandom_range(0, 3) == 0);
         jump       = ($urandom_range(0, 5) == 0);
         jump_reg   = ($urandom_range(0, 7) == 0);
         zero       = 1'($urandom);
         imm16      = 16'($urandom);
         target26   = 26'($urandom);
         rs_data    = $urandom;
         if ($urandom_range(0, 7) != 0) rs_data[1:0] = 2'b00;
         #1;
         n_tests++;
         if (next_pc !== ref_next() || pc_plus4 !== m_pc + 32'd4) begin
            n_fail++;
            $display("FAIL rand_comb[%0d]: next=%h link=%h want %h/%h",
                     i, next_pc, pc_plus4, ref_next(), m_pc + 32'd4);
         end
         tick();
         n_tests++;
         if (pc !== m_pc || instr_count !== m_cnt[31:0] || halted !== m_halt ||
             misaligned !== m_mis || instr_count4 !== 4'(m_cnt4) || pc4 !== m_pc) begin
            n_fail++;
            $display("FAIL rand_state[%0d]: pc=%h cnt=%0d h=%b m=%b cnt4=%0d want %h/%0d/%b/%b/%0d",
                     i, pc, instr_count, halted, misaligned, instr_count4,
                     m_pc, m_cnt, m_halt, m_mis, m_cnt4);
         end
      end
   endtask

   initial begin
      m_pc = 0; m_cnt = 0; m_cnt4 = 0; m_halt = 0; m_mis = 0;
      rst_n = 0;
      idle();
      @(posedge clk);
      #1;
      test_reset();
      test_branch();
      test_jump();
      test_misaligned();
      test_stall_halt();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program counter register and next-PC resolution stage of the single-cycle MIPS core.
- Sits downstream of the control decoder and consumes its Branch, BranchNot, Jump and JumpReg outputs, together with the ALU zero flag.
- Drives the instruction memory address and supplies the PC+4 link value used by the JAL write-back path.
- Adds stall, halt and misaligned-JR detection, plus a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on clk rising edge
stall  input  1  hold PC and counter this cycle
halt_req  input  1  enter HALT at this edge (break/syscall decode)
branch  input  1  control Branch (beq)
branch_not  input  1  control BranchNot (bne)
jump  input  1  control Jump (j/jal)
jump_reg  input  1  control JumpReg (jr)
zero  input  1  ALU zero flag
imm16  input  16  instruction[15:0]
target26  input  26  instruction[25:0]
rs_data  input  32  register file read port 1 (jr target)
pc  output  32  current PC / instruction memory address
pc_plus4  output  32  pc+4; the JAL link value
next_pc  output  32  combinational selected next PC
halted  output  1  state == HALT
misaligned  output  1  sticky; jr target had bits [1:0] != 0
instr_count  output  CNT_W  retired instructions, saturating

Behaviour:
- Reset (rst_n=0 at rising edge) overrides everything and may occur mid-operation, including in HALT:
  - pc=RESET_PC, instr_count=0, halted=0, misaligned=0, state=RUN.
- Combinational logic, all arithmetic modulo 2^32 with carries discarded:
  - pc_plus4 = pc + 4.
  - br_target = pc_plus4 + (sign_extend(imm16) << 2).
  - j_target = {pc_plus4[31:28], target26, 2'b00}.
  - take_br = (branch & zero) | (branch_not & ~zero).
- next_pc priority:
  - jump_reg -> rs_data
  - else jump -> j_target
  - else take_br -> br_target
  - else pc_plus4
- next_pc is driven even while stalled or halted; it is informational only.
- State machine: two states, RUN and HALT.
- RUN, evaluated per rising edge in this priority order:
  1. jump_reg=1 and rs_data[1:0]!=0: pc holds, misaligned<=1, go to HALT, counter unchanged. This wins over halt_req and stall.
  2. halt_req=1: pc holds, go to HALT, counter unchanged. This wins over stall.
  3. stall=1: pc and counter hold, stay in RUN.
  4. Otherwise: pc<=next_pc, instr_count<=instr_count+1, saturating at all-ones (no wrap).
- HALT: pc, counter and misaligned all hold; every input except rst_n is ignored. Only reset exits HALT.
- Latency:
  - pc updates one clock after its inputs are sampled.
  - halted asserts in the cycle after the triggering edge.
  - No combinational path from halt_req or stall to pc.
- Both branch and branch_not high at once: take_br=1 regardless of zero. The decoder never does this; the bench checks the defined result.
- Misalignment of branch and jump targets is impossible by construction; only jr is checked.

Test Plan:
- Reset/sequential: hold rst_n=0 for 2 cycles, release, no control inputs -> pc=0x0 then 0x4, 0x8, 0xC; instr_count=3 after 3 edges; assert rst_n=0 mid-run -> pc=0x0, count=0 on the next edge.
- Branch:
  - pc=0x40, branch=1, zero=1, imm16=16'hFFFE -> next_pc=0x3C, pc=0x3C after the edge.
  - Same inputs with zero=0 -> pc=0x44.
  - branch_not=1, zero=0, imm16=16'h0003 from pc=0x40 -> pc=0x50.
- Jump and priority:
  - pc=0x1000_0040, jump=1, target26=26'h10 -> pc=0x1000_0040; pc_plus4 before the edge = 0x1000_0044 (link value).
  - jump_reg=1, jump=1, rs_data=0x200 -> pc=0x200 (jr wins).
- Misaligned jr: pc=0x80, jump_reg=1, rs_data=0x1003, halt_req=1 -> pc stays 0x80, misaligned=1, halted=1; later stimulus changes nothing; rst_n=0 clears all flags.
- Stall/halt: stall=1 for 3 cycles from pc=0x20 -> pc=0x20, count unchanged; halt_req=1 with stall=1 -> halted=1, pc=0x20.
- Saturation: CNT_W=4, run 20 unstalled cycles -> instr_count=4'hF, holding, while pc keeps advancing (0x50 after 20 cycles from 0x0).
